axi_lite_read_slave: RTL and testbench

AXI4-Lite read-channel responder: accepts read addresses on AR, fetches the addressed word from the register bank over a one-cycle-latency read port, and returns it on R with RRESP. It is the slave-side read path paired with the existing write path and sits between the interconnect and the peripheral register bank. It supports one outstanding read at a time.

---
 rtl/axi_lite_read_slave.sv | 141 ++++++++++++++
 tb/tb_axi_lite_read_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_read_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_read_slave
//
// AXI4-Lite read-channel responder for the peripheral register bank. It accepts
// one read address at a time on AR, issues a single-cycle strobe to the bank,
// captures the returned word and presents it on R until the master takes it.
// Word indices at or beyond NUM_REGS are never sent to the bank. They complete
// with RDATA = 0 and RRESP = SLVERR.
//
// Ports
//   ACLK         in   clock, all state on the rising edge
//   ARESETn      in   synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   ARADDR       in   read byte address; bits [1:0] are ignored
//   ARVALID      in   read address valid
//   ARREADY      out  address accepted when high (decoded from the FSM state)
//   RDATA        out  read data, held stable while RVALID is high
//   RRESP        out  2'b00 OKAY, 2'b10 SLVERR
//   RVALID       out  read data valid
//   RREADY       in   master ready for read data
//   reg_rd_en    out  one-cycle read strobe to the bank
//   reg_rd_addr  out  word index to the bank
//   reg_rd_data  in   bank data, sampled on the edge that ends the strobe cycle
// ----------------------------------------------------------------------------
module axi_lite_read_slave #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              reg_rd_en,
    output logic [ADDR_W-3:0] reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data
);

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               err_q,    err_d;
    logic               rd_en_q,  rd_en_d;
    logic [DATA_W-1:0]  rdata_q,  rdata_d;
    logic [1:0]         rresp_q,  rresp_d;
    logic               rvalid_q, rvalid_d;

    logic [IDX_W-1:0]   ar_idx;
    logic               ar_err;
    logic               unused_addr_lsbs;

    // Byte lanes within a word carry no meaning for 32-bit register reads.
    assign ar_idx           = ARADDR[ADDR_W-1:2];
    assign unused_addr_lsbs = ^ARADDR[1:0];
    assign ar_err           = 32'(ar_idx) >= 32'(NUM_REGS);

    // ARREADY is a pure state decode, so it never depends on ARVALID.
    assign ARREADY     = (state_q == IDLE);
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign RVALID      = rvalid_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_rd_addr = idx_q;

    always_comb begin
        // NOTE: every signal gets a hold/idle default first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        rd_en_d  = 1'b0;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;

        unique case (state_q)
            IDLE: begin
                if (ARVALID) begin
                    idx_d   = ar_idx;
                    err_d   = ar_err;
                    // Strobe is registered, so it is high for exactly the FETCH cycle.
                    rd_en_d = !ar_err;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rdata_d  = err_q ? '0 : reg_rd_data;
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                // The R beat is held until it is accepted; RREADY only ends it.
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together
            // from the values that were present before the edge.
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            rd_en_q  <= rd_en_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_read_slave
//
// Bench for axi_lite_read_slave. The register bank is an array that drives
// data only while the strobe is high. Otherwise it drives a marker pattern, so
// a capture on the wrong cycle returns the wrong data. The reference model keeps
// the outstanding read: accept cycle, index, error flag and expected data.
// From those it computes what every output must be in the current cycle.
// Directed sequences run first, then randomized traffic with random RREADY
// stalls and occasional resets.
// ----------------------------------------------------------------------------
module tb_axi_lite_read_slave;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    logic              ACLK = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              rready;
    logic              reg_rd_en;
    logic [ADDR_W-3:0] reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bank [NUM_REGS];

    axi_lite_read_slave #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (rst),
        .ARADDR     (araddr),
        .ARVALID    (arvalid),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (rready),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data)
    );

    always #5 ACLK = ~ACLK;

    // Bank: valid data only during the strobe cycle.
    always_comb begin
        reg_rd_data = 32'hBAD0_0000 | 32'(reg_rd_addr);
        if (reg_rd_en && int'(reg_rd_addr) < NUM_REGS)
            reg_rd_data = bank[reg_rd_addr[3:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. One outstanding read. It is accepted on an edge where
    // the slave is free and ARVALID is high. The cycle after acceptance is the
    // strobe cycle. From the cycle after that, the beat is shown until an edge
    // with RREADY high.
    // ------------------------------------------------------------------
    int unsigned       cyc      = 0;
    bit                model_on = 1'b0;
    bit                pending  = 1'b0;
    int unsigned       acc_cyc  = 0;
    bit                m_err    = 1'b0;
    logic [5:0]        m_addr   = '0;
    logic [DATA_W-1:0] m_rdata  = '0;
    logic [1:0]        m_rresp  = '0;
    int                beats    = 0;

    always @(posedge ACLK) begin
        cyc++;
        if (rst) begin
            model_on = 1'b1;
            pending  = 1'b0;
            m_err    = 1'b0;
            m_addr   = '0;
            m_rdata  = '0;
            m_rresp  = 2'b00;
        end else if (!pending) begin
            if (arvalid) begin
                pending = 1'b1;
                acc_cyc = cyc;
                m_addr  = araddr[7:2];
                m_err   = int'(m_addr) >= NUM_REGS;
                m_rdata = m_err ? 32'h0 : bank[m_addr[3:0]];
                m_rresp = m_err ? 2'b10 : 2'b00;
            end
        end else if (cyc > acc_cyc + 1 && rready) begin
            pending = 1'b0;
            beats++;
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge ACLK) begin
        if (model_on) begin
            bit exp_en, exp_rvalid;
            exp_en     = pending && (cyc == acc_cyc) && !m_err;
            exp_rvalid = pending && (cyc > acc_cyc);
            check("cmp_arready", 32'(ARREADY), 32'(!pending));
            check("cmp_rvalid", 32'(RVALID), 32'(exp_rvalid));
            check("cmp_rd_en", 32'(reg_rd_en), 32'(exp_en));
            if (exp_en)
                check("cmp_rd_addr", 32'(reg_rd_addr), 32'(m_addr));
            if (exp_rvalid) begin
                check("cmp_rdata", RDATA, m_rdata);
                check("cmp_rresp", 32'(RRESP), 32'(m_rresp));
            end
        end
    end

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Wait (bounded) for a falling edge with ARREADY high; ok=0 on timeout.
    task automatic wait_arready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (ARREADY) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        check("arready_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int unsigned hs_cyc [3];
        bit          hs;
        logic [5:0]  ridx;

        for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
        bank[3] = 32'hDEADBEEF;

        // Reset for 3 edges with ARVALID high.
        rst = 1'b1; arvalid = 1'b1; araddr = 8'h0C; rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rvalid", 32'(RVALID), 32'd0);
            check("rst_rresp", 32'(RRESP), 32'd0);
            check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        end
        rst = 1'b0; arvalid = 1'b0;
        step();
        check("rst_arready", 32'(ARREADY), 32'd1);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_rd_addr", 32'(reg_rd_addr), 32'd0);

        // Single read of word 3.
        araddr = 8'h0C; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        check("single_rd_en", 32'(reg_rd_en), 32'd1);
        check("single_rd_addr", 32'(reg_rd_addr), 32'd3);
        check("single_arready", 32'(ARREADY), 32'd0);
        check("single_rvalid_early", 32'(RVALID), 32'd0);
        step();
        check("single_rvalid", 32'(RVALID), 32'd1);
        check("single_rdata", RDATA, 32'hDEADBEEF);
        check("single_rresp", 32'(RRESP), 32'd0);
        check("single_rd_en_off", 32'(reg_rd_en), 32'd0);
        check("model_pin_rdata", m_rdata, 32'hDEADBEEF);
        step();
        check("single_done_rvalid", 32'(RVALID), 32'd0);
        check("single_done_arready", 32'(ARREADY), 32'd1);

        // Backpressure: a second address is presented and must wait.
        araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
        step();
        araddr = 8'h10;
        check("bp_arready", 32'(ARREADY), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid", 32'(RVALID), 32'd1);
            check("bp_rdata", RDATA, 32'hDEADBEEF);
            check("bp_rresp", 32'(RRESP), 32'd0);
            check("bp_arready_hold", 32'(ARREADY), 32'd0);
            check("bp_rd_en", 32'(reg_rd_en), 32'd0);
            step();
        end
        rready = 1'b1;
        step();
        check("bp_done_rvalid", 32'(RVALID), 32'd0);
        check("bp_done_arready", 32'(ARREADY), 32'd1);
        step();
        arvalid = 1'b0;
        check("bp_second_rd_en", 32'(reg_rd_en), 32'd1);
        check("bp_second_rd_addr", 32'(reg_rd_addr), 32'd4);
        step();
        check("bp_second_rdata", RDATA, bank[4]);
        step();

        // Out of range: word 16 lies beyond the last bank entry.
        araddr = 8'h40; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        check("oor_rd_en", 32'(reg_rd_en), 32'd0);
        check("oor_arready", 32'(ARREADY), 32'd0);
        step();
        check("oor_rvalid", 32'(RVALID), 32'd1);
        check("oor_rdata", RDATA, 32'h0);
        check("oor_rresp", 32'(RRESP), 32'd2);
        step();
        check("oor_idle", 32'(ARREADY), 32'd1);
        check("oor_rvalid_off", 32'(RVALID), 32'd0);

        // Back-to-back with ARVALID held and RREADY high.
        araddr = 8'h00; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_arready(ok);
            hs_cyc[i] = cyc;
            step();
            araddr = 8'((i + 1) * 4);
        end
        arvalid = 1'b0;
        check("b2b_gap01", hs_cyc[1] - hs_cyc[0], 32'd3);
        check("b2b_gap12", hs_cyc[2] - hs_cyc[1], 32'd3);
        step();
        check("b2b_last_rdata", RDATA, bank[2]);
        step();

        // Reset during the FETCH cycle discards the read.
        araddr = 8'h14; arvalid = 1'b1; rready = 1'b1;
        step();
        rst = 1'b1; arvalid = 1'b0;
        step();
        rst = 1'b0;
        check("midrst_rvalid", 32'(RVALID), 32'd0);
        check("midrst_arready", 32'(ARREADY), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("midrst_no_beat", 32'(RVALID), 32'd0);
        end

        // Randomized traffic: AXI-legal ARVALID, random stalls and resets.
        for (int c = 0; c < 3000; c++) begin
            hs = arvalid && ARREADY && !rst;
            @(posedge ACLK);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                arvalid = 1'b0;
            end
            if (!rst) begin
                if (hs) arvalid = 1'b0;
                if (!arvalid && $urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 9) < 7) ridx = 6'($urandom_range(0, NUM_REGS - 1));
                    else ridx = 6'($urandom_range(NUM_REGS, 63));
                    araddr  = {ridx, 2'($urandom_range(0, 3))};
                    arvalid = 1'b1;
                end
            end
            rready = ($urandom_range(0, 3) != 0);
            @(negedge ACLK);
        end
        rst = 1'b0; arvalid = 1'b0; rready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("random_beats", 32'(beats >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
